// File: rtl/camera_sccb_sequencer_pkg.sv
// Shared definitions for the camera SCCB configuration sequencer: FSM encoding
// and the table sentinel / soft-reset register constants.
package camera_sccb_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CHECK,
    ISSUE,
    WAIT_DONE,
    DELAY,
    FINISH
  } state_t;

  localparam logic [7:0] SENTINEL       = 8'hFF;
  localparam logic [7:0] SOFT_RESET_REG = 8'h12;
  localparam int         SOFT_RESET_BIT = 7;

  function automatic logic is_soft_reset(input logic [7:0] reg_addr, input logic [7:0] reg_data);
    return (reg_addr == SOFT_RESET_REG) && reg_data[SOFT_RESET_BIT];
  endfunction

endpackage

// File: rtl/camera_sccb_sequencer_delay_counter.sv
// Post-soft-reset wait timer: load starts a WAIT_CYCLES countdown and o_expire
// pulses in the last counted cycle.
module sccb_delay_counter
  import camera_sccb_sequencer_pkg::*;
#(
  parameter int WAIT_CYCLES = 48000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  output logic o_expire
);

  // A zero wait would never expire, so the shortest wait is one cycle.
  localparam int LOAD_VAL = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
  localparam int CW       = $clog2(LOAD_VAL + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CW'(LOAD_VAL);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_expire = (r_cnt == CW'(1));

endmodule

// File: rtl/camera_sccb_sequencer.sv
// Walks a register table and writes each entry over SCCB, pausing after a camera soft reset.
// Build option SCCB_NACK_RETRY_EN: NACKed writes are retried up to MAX_RETRY times.
module camera_sccb_sequencer
  import camera_sccb_sequencer_pkg::*;
#(
  parameter int RESET_WAIT = 48000,
  parameter int MAX_RETRY  = 3
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  output logic [7:0] o_tbl_index,
  input  logic [7:0] i_tbl_addr,
  input  logic [7:0] i_tbl_value,
  output logic       o_sccb_req,
  output logic [7:0] o_sccb_reg,
  output logic [7:0] o_sccb_data,
  input  logic       i_sccb_busy,
  input  logic       i_sccb_done,
  input  logic       i_sccb_nack,
  output logic       o_busy,
  output logic       o_config_done,
  output logic       o_error,
  output logic [7:0] o_entry_count
);

  if (MAX_RETRY < 0 || MAX_RETRY > 254) begin : g_bad_max_retry
    $error("MAX_RETRY must be within 0..254");
  end

  state_t     r_state, w_state_nxt;
  logic [7:0] r_tbl_index, w_tbl_index_nxt;
  logic       r_sccb_req, w_sccb_req_nxt;
  logic [7:0] r_sccb_reg, w_sccb_reg_nxt;
  logic [7:0] r_sccb_data, w_sccb_data_nxt;
  logic       r_busy, w_busy_nxt;
  logic       r_config_done, w_config_done_nxt;
  logic       r_error, w_error_nxt;
  logic [7:0] r_entry_count, w_entry_count_nxt;
  logic       w_delay_load;
  logic       w_delay_expire;
  logic       w_advance;

`ifdef SCCB_NACK_RETRY_EN
  localparam int          RW          = $clog2(MAX_RETRY + 2);
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);
  logic [RW-1:0] r_retry_cnt, w_retry_cnt_nxt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_retry_cnt <= '0;
    end else begin
      r_retry_cnt <= w_retry_cnt_nxt;
    end
  end
`endif

  sccb_delay_counter #(
    .WAIT_CYCLES(RESET_WAIT)
  ) u_delay (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (w_delay_load),
    .o_expire(w_delay_expire)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= IDLE;
      r_tbl_index   <= 8'd0;
      r_sccb_req    <= 1'b0;
      r_sccb_reg    <= 8'd0;
      r_sccb_data   <= 8'd0;
      r_busy        <= 1'b0;
      r_config_done <= 1'b0;
      r_error       <= 1'b0;
      r_entry_count <= 8'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_tbl_index   <= w_tbl_index_nxt;
      r_sccb_req    <= w_sccb_req_nxt;
      r_sccb_reg    <= w_sccb_reg_nxt;
      r_sccb_data   <= w_sccb_data_nxt;
      r_busy        <= w_busy_nxt;
      r_config_done <= w_config_done_nxt;
      r_error       <= w_error_nxt;
      r_entry_count <= w_entry_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_tbl_index_nxt   = r_tbl_index;
    w_sccb_req_nxt    = 1'b0;
    w_sccb_reg_nxt    = r_sccb_reg;
    w_sccb_data_nxt   = r_sccb_data;
    w_busy_nxt        = r_busy;
    w_config_done_nxt = r_config_done;
    w_error_nxt       = r_error;
    w_entry_count_nxt = r_entry_count;
    w_delay_load      = 1'b0;
    w_advance         = 1'b0;
`ifdef SCCB_NACK_RETRY_EN
    w_retry_cnt_nxt   = r_retry_cnt;
`endif

    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_tbl_index_nxt   = 8'd0;
          w_config_done_nxt = 1'b0;
          w_error_nxt       = 1'b0;
          w_entry_count_nxt = 8'd0;
          w_busy_nxt        = 1'b1;
          w_state_nxt       = FETCH;
        end
      end
      FETCH: w_state_nxt = CHECK;
      CHECK: begin
        if (i_tbl_addr == SENTINEL && i_tbl_value == SENTINEL) begin
          w_state_nxt = FINISH;
        end else begin
          w_sccb_reg_nxt  = i_tbl_addr;
          w_sccb_data_nxt = i_tbl_value;
          w_state_nxt     = ISSUE;
`ifdef SCCB_NACK_RETRY_EN
          w_retry_cnt_nxt = '0;
`endif
        end
      end
      ISSUE: begin
        if (!i_sccb_busy) begin
          w_sccb_req_nxt = 1'b1;
          w_state_nxt    = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (i_sccb_done) begin
          if (!i_sccb_nack) begin
            w_entry_count_nxt = r_entry_count + 8'd1;
            if (is_soft_reset(r_sccb_reg, r_sccb_data)) begin
              w_delay_load = 1'b1;
              w_state_nxt  = DELAY;
            end else begin
              w_advance = 1'b1;
            end
          end else begin
`ifdef SCCB_NACK_RETRY_EN
            if (r_retry_cnt < RETRY_LIMIT) begin
              w_retry_cnt_nxt = r_retry_cnt + RW'(1);
              w_state_nxt     = ISSUE;
            end else begin
              w_error_nxt = 1'b1;
              w_advance   = 1'b1;
            end
`else
            w_error_nxt = 1'b1;
            w_advance   = 1'b1;
`endif
          end
        end
      end
      DELAY: begin
        if (w_delay_expire) begin
          w_advance = 1'b1;
        end
      end
      FINISH: begin
        w_config_done_nxt = 1'b1;
        w_busy_nxt        = 1'b0;
        w_state_nxt       = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase

    // The last table slot has no successor: the index holds and the pass is flagged.
    if (w_advance) begin
      if (r_tbl_index == 8'hFF) begin
        w_error_nxt = 1'b1;
        w_state_nxt = FINISH;
      end else begin
        w_tbl_index_nxt = r_tbl_index + 8'd1;
        w_state_nxt     = FETCH;
      end
    end
  end

  assign o_tbl_index   = r_tbl_index;
  assign o_sccb_req    = r_sccb_req;
  assign o_sccb_reg    = r_sccb_reg;
  assign o_sccb_data   = r_sccb_data;
  assign o_busy        = r_busy;
  assign o_config_done = r_config_done;
  assign o_error       = r_error;
  assign o_entry_count = r_entry_count;

endmodule

// File: tb/tb_camera_sccb_sequencer.sv
// Scoreboard bench for camera_sccb_sequencer: table ROM and SCCB master models,
// a pass-level reference model, and a monitor that checks every write request.
module tb_camera_sccb_sequencer;

  localparam int W  = 40;
  localparam int MR = 3;
`ifdef SCCB_NACK_RETRY_EN
  localparam int ATTEMPTS = MR + 1;
`else
  localparam int ATTEMPTS = 1;
`endif

  typedef struct {
    logic [7:0] a;
    logic [7:0] v;
    int         gap;  // 0: unchecked, 1: back-to-back, 2: after soft-reset wait
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] tbl_index;
  logic [7:0] tbl_addr = 8'd0;
  logic [7:0] tbl_value = 8'd0;
  logic       sccb_req;
  logic [7:0] sccb_reg, sccb_data;
  logic       m_busy = 1'b0, hold_busy = 1'b0;
  logic       m_done = 1'b0, spur_done = 1'b0, m_nack = 1'b0;
  logic       sccb_busy, sccb_done;
  logic       busy, config_done, error;
  logic [7:0] entry_count;

  int checks = 0;
  int failures = 0;

  logic [7:0] tbl_a [256];
  logic [7:0] tbl_v [256];
  int         plan  [256];
  exp_t       exp_q [$];
  bit         nack_q[$];
  logic [7:0] e_cnt, e_idx;
  bit         e_err;
  int         cyc = 0;
  int         last_done_cyc = 0;
  int         req_seen = 0;

  assign sccb_busy = m_busy | hold_busy;
  assign sccb_done = m_done | spur_done;

  always #5 clk = ~clk;

  camera_sccb_sequencer #(
    .RESET_WAIT(W),
    .MAX_RETRY (MR)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .o_tbl_index  (tbl_index),
    .i_tbl_addr   (tbl_addr),
    .i_tbl_value  (tbl_value),
    .o_sccb_req   (sccb_req),
    .o_sccb_reg   (sccb_reg),
    .o_sccb_data  (sccb_data),
    .i_sccb_busy  (sccb_busy),
    .i_sccb_done  (sccb_done),
    .i_sccb_nack  (m_nack),
    .o_busy       (busy),
    .o_config_done(config_done),
    .o_error      (error),
    .o_entry_count(entry_count)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
    end
  endtask

  // Table ROM with one cycle of read latency.
  initial begin : table_rom
    logic [7:0] idx;
    forever begin
      @(negedge clk);
      idx = tbl_index;
      @(posedge clk);
      #1;
      tbl_addr  = tbl_a[idx];
      tbl_value = tbl_v[idx];
    end
  end

  // SCCB master: answers each request after a random busy period.
  initial begin : sccb_master
    bit nk;
    forever begin
      @(negedge clk);
      if (rst_n && sccb_req) begin
        nk = (nack_q.size() != 0) ? nack_q.pop_front() : 1'b0;
        @(posedge clk);
        #1 m_busy = 1'b1;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        @(posedge clk);
        #1;
        m_busy = 1'b0;
        m_done = 1'b1;
        m_nack = nk;
        @(posedge clk);
        #1;
        m_done = 1'b0;
        m_nack = 1'b0;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        cyc++;
        if (m_done) last_done_cyc = cyc;
        if (sccb_req) begin
          req_seen++;
          chk("req_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("req_reg", sccb_reg, e.a);
            chk("req_data", sccb_data, e.v);
            if (e.gap == 1) chk("short_gap", (cyc - last_done_cyc) < W, 1);
            if (e.gap == 2) chk("long_gap", (cyc - last_done_cyc) >= W, 1);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic clear_tbl();
    for (int i = 0; i < 256; i++) begin
      tbl_a[i] = 8'hFF;
      tbl_v[i] = 8'hFF;
      plan[i]  = 0;
    end
  endtask

  task automatic set_ent(input int i, input logic [7:0] a, input logic [7:0] v);
    tbl_a[i] = a;
    tbl_v[i] = v;
  endtask

  // Reference: what a pass over the current table and NACK plan must produce.
  task automatic model_pass();
    int   acks = 0;
    bit   err = 1'b0;
    int   last_idx = 255;
    int   gap = 0;
    bit   nk;
    exp_t e;
    exp_q.delete();
    nack_q.delete();
    for (int i = 0; i < 256; i++) begin
      if (tbl_a[i] == 8'hFF && tbl_v[i] == 8'hFF) begin
        last_idx = i;
        break;
      end
      for (int a = 0; a < ATTEMPTS; a++) begin
        nk = (a < plan[i]);
        e = '{a: tbl_a[i], v: tbl_v[i], gap: gap};
        exp_q.push_back(e);
        nack_q.push_back(nk);
        gap = 1;
        if (!nk) begin
          acks++;
          if (tbl_a[i] == 8'h12 && tbl_v[i][7]) gap = 2;
          break;
        end
        if (a == ATTEMPTS - 1) err = 1'b1;
      end
      if (i == 255) err = 1'b1;
    end
    e_cnt = 8'(acks);
    e_err = err;
    e_idx = 8'(last_idx);
  endtask

  task automatic start_pass();
    model_pass();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic finish_pass(input string tag, input int budget);
    int n = 0;
    while (!config_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".timeout"}, n < budget, 1);
    @(negedge clk);
    chk({tag, ".config_done"}, config_done, 1);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".error"}, error, e_err);
    chk({tag, ".entry_count"}, entry_count, e_cnt);
    chk({tag, ".tbl_index"}, tbl_index, e_idx);
    chk({tag, ".pending_writes"}, exp_q.size(), 0);
  endtask

  initial begin : stimulus
    int r0;
    int k;
    logic [7:0] a, v;

    clear_tbl();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst.tbl_index", tbl_index, 0);
    chk("rst.sccb_req", sccb_req, 0);
    chk("rst.sccb_reg", sccb_reg, 0);
    chk("rst.sccb_data", sccb_data, 0);
    chk("rst.busy", busy, 0);
    chk("rst.config_done", config_done, 0);
    chk("rst.error", error, 0);
    chk("rst.entry_count", entry_count, 0);

    // Soft-reset entry followed by a plain write.
    clear_tbl();
    set_ent(0, 8'h12, 8'h80);
    set_ent(1, 8'h11, 8'h01);
    start_pass();
    @(negedge clk);
    chk("softreset.busy_set", busy, 1);
    finish_pass("softreset", 2000);

    // Entry 0 is never acknowledged.
    clear_tbl();
    set_ent(0, 8'h3A, 8'h55);
    plan[0] = 100;
    set_ent(1, 8'h3B, 8'h66);
    r0 = req_seen;
    start_pass();
    finish_pass("nack", 2000);
    chk("nack.req_count", req_seen - r0, ATTEMPTS + 1);

    // Bus held busy at ISSUE, with a stray DONE and a second START meanwhile.
    clear_tbl();
    set_ent(0, 8'h20, 8'h01);
    set_ent(1, 8'h21, 8'h02);
    hold_busy = 1'b1;
    r0 = req_seen;
    start_pass();
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      spur_done = (c == 3);
      start     = (c == 6);
    end
    @(negedge clk);
    chk("hold.no_req", req_seen - r0, 0);
    @(posedge clk);
    #1;
    spur_done = 1'b0;
    start     = 1'b0;
    hold_busy = 1'b0;
    k = 0;
    while (k < 5) begin
      @(negedge clk);
      k++;
      if (sccb_req) break;
    end
    chk("hold.req_on_release", sccb_req && (k <= 2), 1);
    finish_pass("hold", 2000);

    // Reset in the middle of the post-soft-reset wait.
    clear_tbl();
    set_ent(0, 8'h12, 8'h80);
    set_ent(1, 8'h11, 8'h01);
    start_pass();
    k = 0;
    while (!m_done && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("rstdly.first_done", k < 200, 1);
    repeat (5) @(negedge clk);
    chk("rstdly.pre_count", entry_count, 1);
    chk("rstdly.pre_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstdly.outputs_cleared",
        {busy, config_done, error, sccb_req, entry_count, tbl_index, sccb_reg, sccb_data}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    start_pass();
    finish_pass("rstdly.rerun", 2000);

    // Random tables with random NACK plans.
    for (int p = 0; p < 6; p++) begin
      clear_tbl();
      k = $urandom_range(1, 12);
      for (int i = 0; i < k; i++) begin
        a = 8'($urandom_range(0, 254));
        v = 8'($urandom);
        if ($urandom_range(0, 5) == 0) begin
          a = 8'h12;
          v = v | 8'h80;
        end
        set_ent(i, a, v);
        plan[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
      end
      start_pass();
      finish_pass($sformatf("rand%0d", p), 20000);
    end

    // Full table with no sentinel.
    clear_tbl();
    for (int i = 0; i < 256; i++) begin
      a = 8'($urandom_range(0, 254));
      if (a == 8'h12) a = 8'h13;
      set_ent(i, a, 8'($urandom));
    end
    r0 = req_seen;
    start_pass();
    finish_pass("full", 20000);
    chk("full.req_count", req_seen - r0, 256);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
